// File: rtl/packet_assembler_pkg.sv
// Shared state encoding and the bitwise CRC-8 update used by the packet assembler.
package packet_assembler_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        OUTPUT  = 2'd2
    } pa_state_t;

    // MSB-first, non-reflected CRC-8 over one byte; no final XOR.
    function automatic logic [7:0] crc8_step(
        input logic [7:0] crc,
        input logic [7:0] data,
        input logic [7:0] poly
    );
        logic [7:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            c = {c[6:0], 1'b0} ^ ((c[7] ^ data[i]) ? poly : 8'h00);
        end
        return c;
    endfunction

endpackage

// File: rtl/packet_assembler_crc8_engine.sv
// Running CRC-8 register; clear restarts from CRC_INIT and folds in a same-cycle byte.
module crc8_engine
    import packet_assembler_pkg::*;
#(
    parameter logic [7:0] CRC_POLY = 8'h07,
    parameter logic [7:0] CRC_INIT = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       data_valid,
    input  logic [7:0] data,
    output logic [7:0] crc
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            crc <= CRC_INIT;
        end else if (clear) begin
            crc <= data_valid ? crc8_step(CRC_INIT, data, CRC_POLY) : CRC_INIT;
        end else if (data_valid) begin
            crc <= crc8_step(crc, data, CRC_POLY);
        end
    end

endmodule

// File: rtl/packet_assembler.sv
// UART byte stream to CRC-checked message assembler with valid/ready output.
// Optional inter-byte timeout abort is enabled by defining PACKET_ASSEMBLER_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for byte 0 of a packet; CRC held at init
// RECEIVE | collecting payload bytes, then the CRC byte
// OUTPUT  | checked message presented until downstream takes it
module packet_assembler
    import packet_assembler_pkg::*;
#(
    parameter int         MESSAGE_BYTES  = 6,
    parameter logic [7:0] CRC_POLY       = 8'h07,
    parameter logic [7:0] CRC_INIT       = 8'h00,
    parameter int         TIMEOUT_CYCLES = 10000,
    parameter int         ERR_CNT_WIDTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 i_data,
    input  logic                       i_valid,
    output logic                       o_ready,
    output logic [8*MESSAGE_BYTES-1:0] o_message,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic                       o_crc_error,
    output logic                       o_timeout,
    output logic [ERR_CNT_WIDTH-1:0]   o_crc_err_count,
    output logic                       o_busy
);

    localparam int IDX_W = $clog2(MESSAGE_BYTES + 1);
    localparam logic [IDX_W-1:0] CRC_IDX = IDX_W'(MESSAGE_BYTES);

    if (MESSAGE_BYTES < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("packet_assembler: MESSAGE_BYTES must be >= 1 and TIMEOUT_CYCLES >= 2");
    end

    pa_state_t                  state;
    pa_state_t                  state_next;
    logic [IDX_W-1:0]           idx;
    logic [8*MESSAGE_BYTES-1:0] payload;
    logic [7:0]                 crc;
    logic                       accept;
    logic                       data_byte;
    logic                       crc_byte;
    logic                       crc_good;
    logic                       crc_bad;
    logic                       timeout_hit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = RECEIVE;
            RECEIVE: begin
                if (crc_good) begin
                    state_next = OUTPUT;
                end else if (crc_bad || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            OUTPUT:  if (i_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state != OUTPUT);
        o_valid = (state == OUTPUT);
        o_busy  = (state != IDLE);
    end

    // idx is 0 in IDLE, so byte 0 is always a payload byte even when MESSAGE_BYTES is 1.
    assign accept    = i_valid && o_ready;
    assign data_byte = accept && (idx != CRC_IDX);
    assign crc_byte  = accept && (state == RECEIVE) && (idx == CRC_IDX);
    assign crc_good  = crc_byte && (i_data == crc);
    assign crc_bad   = crc_byte && (i_data != crc);

    crc8_engine #(
        .CRC_POLY (CRC_POLY),
        .CRC_INIT (CRC_INIT)
    ) u_crc (
        .clk        (clk),
        .reset      (reset),
        .clear      (state == IDLE),
        .data_valid (data_byte),
        .data       (i_data),
        .crc        (crc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx             <= '0;
            payload         <= '0;
            o_message       <= '0;
            o_crc_error     <= 1'b0;
            o_crc_err_count <= '0;
        end else begin
            o_crc_error <= crc_bad;
            if (crc_byte || timeout_hit) begin
                idx <= '0;
            end else if (data_byte) begin
                idx <= idx + 1'b1;
            end
            for (int k = 0; k < MESSAGE_BYTES; k++) begin
                if (data_byte && idx == IDX_W'(k)) begin
                    payload[8*k +: 8] <= i_data;
                end
            end
            if (crc_good) begin
                o_message <= payload;
            end
            if (crc_bad && o_crc_err_count != '1) begin
                o_crc_err_count <= o_crc_err_count + 1'b1;
            end
        end
    end

`ifdef PACKET_ASSEMBLER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    logic [TMR_W-1:0] timer;
    logic             timeout_pulse;

    // Down-counter reloaded on each accepted byte; zero while still idle means threshold reached.
    assign timeout_hit = (state == RECEIVE) && !accept && (timer == '0);
    assign o_timeout   = timeout_pulse;

    always_ff @(posedge clk) begin
        if (!reset) begin
            timer         <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= timeout_hit;
            if (state_next != RECEIVE) begin
                timer <= '0;
            end else if (accept) begin
                timer <= TMR_W'(TIMEOUT_CYCLES - 1);
            end else begin
                timer <= timer - 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign o_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_packet_assembler.sv
// Randomized self-checking bench: a 6-byte instance and a 9-byte / 2-bit-counter instance.
module tb_packet_assembler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic [7:0]  d_data = 8'h00;
    logic        d_valid = 1'b0;
    logic        d_ready = 1'b0;

    logic        a_ready, a_valid, a_err, a_to, a_busy;
    logic [47:0] a_msg;
    logic [7:0]  a_cnt;
    logic        b_ready, b_valid, b_err, b_to, b_busy;
    logic [71:0] b_msg;
    logic [1:0]  b_cnt;

    logic        obs_ready, obs_valid, obs_err, obs_to, obs_busy;
    logic [71:0] obs_msg;
    logic [7:0]  obs_cnt;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cnt_a = 0;
    int          cnt_b = 0;
    logic [7:0]  pl[$];

    always #5 clk = ~clk;

    packet_assembler dut_a (
        .clk             (clk),
        .reset           (rst_n),
        .i_data          (d_data),
        .i_valid         (d_valid & ~sel),
        .o_ready         (a_ready),
        .o_message       (a_msg),
        .o_valid         (a_valid),
        .i_ready         (d_ready & ~sel),
        .o_crc_error     (a_err),
        .o_timeout       (a_to),
        .o_crc_err_count (a_cnt),
        .o_busy          (a_busy)
    );

    packet_assembler #(
        .MESSAGE_BYTES  (9),
        .TIMEOUT_CYCLES (16),
        .ERR_CNT_WIDTH  (2)
    ) dut_b (
        .clk             (clk),
        .reset           (rst_n),
        .i_data          (d_data),
        .i_valid         (d_valid & sel),
        .o_ready         (b_ready),
        .o_message       (b_msg),
        .o_valid         (b_valid),
        .i_ready         (d_ready & sel),
        .o_crc_error     (b_err),
        .o_timeout       (b_to),
        .o_crc_err_count (b_cnt),
        .o_busy          (b_busy)
    );

    always_comb begin
        obs_ready = sel ? b_ready : a_ready;
        obs_valid = sel ? b_valid : a_valid;
        obs_err   = sel ? b_err   : a_err;
        obs_to    = sel ? b_to    : a_to;
        obs_busy  = sel ? b_busy  : a_busy;
        obs_msg   = sel ? b_msg   : {24'h0, a_msg};
        obs_cnt   = sel ? {6'h0, b_cnt} : a_cnt;
    end

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // CRC as remainder of message*x^8 divided by the generator, byte-xor long-division form.
    function automatic logic [7:0] model_crc(input logic [7:0] q[$]);
        logic [7:0] r;
        r = 8'h00;
        foreach (q[i]) begin
            r = r ^ q[i];
            repeat (8) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction

    function automatic logic [71:0] model_msg(input logic [7:0] q[$]);
        logic [71:0] m;
        m = '0;
        foreach (q[i]) m[8*i +: 8] = q[i];
        return m;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        chk("ready_for_byte", obs_ready, 1'b1);
        d_data  = b;
        d_valid = 1'b1;
        @(negedge clk);
        d_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends pl[first..] then cb and checks the outcome the model predicts.
    task automatic run_packet(input logic [7:0] q[$], input int first, input logic [7:0] cb,
                              input int hold, input int gap_max);
        logic [71:0] exp_msg;
        bit          good;
        good    = (cb == model_crc(q));
        exp_msg = model_msg(q);
        for (int i = first; i < q.size(); i++) begin
            if (gap_max > 0) idle($urandom_range(0, gap_max));
            send_byte(q[i]);
        end
        if (gap_max > 0) idle($urandom_range(0, gap_max));
        send_byte(cb);
        chk("no_timeout", obs_to, 1'b0);
        if (good) begin
            chk("valid_rise", obs_valid, 1'b1);
            chk("no_crc_err", obs_err, 1'b0);
            chk("message", obs_msg, exp_msg);
            chk("ready_low", obs_ready, 1'b0);
            chk("err_count", obs_cnt, sel ? cnt_b : cnt_a);
            repeat (hold) begin
                @(negedge clk);
                chk("valid_hold", obs_valid, 1'b1);
                chk("msg_stable", obs_msg, exp_msg);
                chk("ready_bp", obs_ready, 1'b0);
            end
            d_ready = 1'b1;
            @(negedge clk);
            d_ready = 1'b0;
            chk("valid_clear", obs_valid, 1'b0);
            chk("ready_after", obs_ready, 1'b1);
        end else begin
            if (sel) cnt_b = (cnt_b < 3) ? cnt_b + 1 : 3;
            else     cnt_a = (cnt_a < 255) ? cnt_a + 1 : 255;
            chk("crc_err_pulse", obs_err, 1'b1);
            chk("no_valid", obs_valid, 1'b0);
            chk("ready_on_err", obs_ready, 1'b1);
            chk("err_count", obs_cnt, sel ? cnt_b : cnt_a);
        end
    endtask

    task automatic rand_payload(input int n);
        pl.delete();
        repeat (n) pl.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, obs_valid, 1'b0);
        chk({tag, "_err"}, obs_err, 1'b0);
        chk({tag, "_to"}, obs_to, 1'b0);
        chk({tag, "_busy"}, obs_busy, 1'b0);
        chk({tag, "_ready"}, obs_ready, 1'b1);
        chk({tag, "_msg"}, obs_msg, 72'h0);
        chk({tag, "_cnt"}, obs_cnt, 8'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cb;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        pl = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_packet(pl, 0, 8'h00, 0, 0);
        pl = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        run_packet(pl, 0, 8'h07, 5, 0);

        for (int n = 0; n < 40; n++) begin
            rand_payload(6);
            cb = model_crc(pl);
            if ($urandom_range(0, 3) == 0) cb = cb ^ 8'($urandom_range(1, 255));
            run_packet(pl, 0, cb, $urandom_range(0, 3), (n % 2) ? 2 : 0);
        end
        rand_payload(6);
        run_packet(pl, 0, model_crc(pl) ^ 8'h80, 0, 0);
        @(negedge clk);
        chk("crc_err_one_cycle", obs_err, 1'b0);

        // reset while byte 4 is on the bus
        rand_payload(6);
        for (int i = 0; i < 4; i++) send_byte(pl[i]);
        d_data = pl[4];
        d_valid = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        d_valid = 1'b0;
        rst_n = 1'b1;
        cnt_a = 0;
        chk_reset_state("rst_mid");
        rand_payload(6);
        run_packet(pl, 0, model_crc(pl), 1, 0);

        // reset while a message is held in OUTPUT
        rand_payload(6);
        run_packet(pl, 0, model_crc(pl) ^ 8'h01, 0, 0);
        pl[0] = pl[0] | 8'h01;
        for (int i = 0; i < 6; i++) send_byte(pl[i]);
        send_byte(model_crc(pl));
        chk("pre_rst_valid", obs_valid, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cnt_a = 0;
        chk_reset_state("rst_out");
        rand_payload(6);
        run_packet(pl, 0, model_crc(pl), 0, 0);

        // 9-byte instance with a 2-bit saturating counter
        sel = 1'b1;
        @(negedge clk);
        pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        run_packet(pl, 0, 8'hF4, 2, 0);
        for (int n = 0; n < 5; n++) run_packet(pl, 0, 8'hF5, 0, 0);
        @(negedge clk);
        chk("b_err_one_cycle", obs_err, 1'b0);
        rand_payload(9);
        run_packet(pl, 0, model_crc(pl), 0, 2);

`ifdef PACKET_ASSEMBLER_TIMEOUT_EN
        rand_payload(9);
        for (int i = 0; i < 3; i++) send_byte(pl[i]);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk("to_pulse", obs_to, k == 16);
            chk("to_busy", obs_busy, k < 16);
        end
        @(negedge clk);
        chk("to_one_cycle", obs_to, 1'b0);
        rand_payload(9);
        run_packet(pl, 0, model_crc(pl), 0, 0);
        rand_payload(9);
        for (int i = 0; i < 3; i++) send_byte(pl[i]);
        idle(15);
        send_byte(pl[3]);
        chk("to_edge_none", obs_to, 1'b0);
        chk("to_edge_busy", obs_busy, 1'b1);
        run_packet(pl, 4, model_crc(pl), 0, 0);
`else
        rand_payload(9);
        for (int i = 0; i < 3; i++) send_byte(pl[i]);
        idle(40);
        chk("no_to_busy", obs_busy, 1'b1);
        chk("no_to_pulse", obs_to, 1'b0);
        run_packet(pl, 3, model_crc(pl), 0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/packet_assembler.md
# packet_assembler

Parametrised successor to the fixed 6+1-byte UART packet merger. Collects a stream of received UART bytes into a `MESSAGE_BYTES`-byte message followed by one CRC-8 byte, and checks the CRC inline with a configurable polynomial and init value. Presents good messages on a valid/ready output. Also reports CRC failures and, optionally, inter-byte timeouts with a saturating error counter. Sits between `UartRx` and the DAQ command decoder.

## Interface
- `MESSAGE_BYTES`, 6, payload bytes per packet (≥1).
- `CRC_POLY`, 8'h07, CRC-8 generator polynomial, x^8 implicit.
- `CRC_INIT`, 8'h00, CRC register value at packet start.
- `TIMEOUT_CYCLES`, 10000, idle cycles mid-packet before abort (≥2, only used with timeout enabled).
- `ERR_CNT_WIDTH`, 8, width of the CRC error counter.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-low.
- `i_data` input 8: received byte.
- `i_valid` input 1: `i_data` valid.
- `o_ready` output 1: block accepts a byte this cycle.
- `o_message` output 8*MESSAGE_BYTES: assembled payload; byte k at `[8k+7:8k]`.
- `o_valid` output 1: `o_message` holds a CRC-checked message.
- `i_ready` input 1: downstream accepts the message.
- `o_crc_error` output 1: one-cycle pulse on CRC mismatch.
- `o_timeout` output 1: one-cycle pulse on timeout abort (tied 0 without the macro).
- `o_crc_err_count` output ERR_CNT_WIDTH: saturating count of CRC mismatches.
- `o_busy` output 1: state ≠ IDLE.

## Operation
- States: IDLE, RECEIVE, OUTPUT.
- A byte is accepted when `i_valid && o_ready`. `o_ready` = 1 in IDLE and RECEIVE, 0 in OUTPUT.
- **IDLE**
  - On accept: store the byte as byte 0, set `crc = step(CRC_INIT, byte)`, set `idx = 1`, go to RECEIVE.
  - If `MESSAGE_BYTES` = 1, still go to RECEIVE; the next byte is the CRC.
- **RECEIVE**
  - On accept with `idx < MESSAGE_BYTES`: store at `idx`, update `crc`, increment `idx`.
  - On accept with `idx == MESSAGE_BYTES` (CRC byte):
    - Byte equals `crc`: latch `o_message`, set `o_valid`, go to OUTPUT.
    - Otherwise: pulse `o_crc_error`, increment the counter (saturating at all-ones), go to IDLE. The message is discarded.
- **OUTPUT**
  - `o_valid` holds and `o_message` stays stable until `i_ready`.
  - On `o_valid && i_ready`: clear `o_valid`, go to IDLE.
  - Input bytes are back-pressured, never dropped.
- **CRC step**
  - MSB-first, non-reflected, no final XOR.
  - For each bit: `crc = {crc[6:0],1'b0} ^ (crc[7]^d_bit ? CRC_POLY : 0)`.
  - The CRC byte itself is compared, not folded into `crc`.
- `idx` width is `$clog2(MESSAGE_BYTES+1)`. No wrap is possible: `idx` resets on every return to IDLE.
- **Reset** (`reset` = 0 at a clock edge, including mid-packet or mid-OUTPUT):
  - State IDLE; `o_valid`, `o_crc_error`, `o_timeout` = 0.
  - `o_message` = 0; `o_crc_err_count` = 0; `idx` = 0; `crc` = `CRC_INIT`; timer = 0.
  - A pending message is lost.

## Timing
- `o_valid` rises on the cycle after the CRC byte is accepted.
- `o_crc_error` is high for exactly the cycle after a bad CRC byte is accepted. `o_ready` is 1 in that cycle, so back-to-back packets are accepted with no gap.
- After `i_ready` handshake, `o_ready` = 1 on the next cycle.
- Throughput is one byte per cycle, and one message per MESSAGE_BYTES+2 cycles with `i_ready` tied high.

## Configuration
- Macro `PACKET_ASSEMBLER_TIMEOUT_EN`.
- **Defined:**
  - In RECEIVE a timer counts consecutive cycles with no accepted byte and clears on every accept.
  - When it reaches `TIMEOUT_CYCLES`: pulse `o_timeout` for one cycle, discard the partial packet, go to IDLE.
  - A byte accepted in the threshold cycle takes priority: no timeout.
  - The timer is inactive in IDLE and OUTPUT.
- **Undefined:** no timer logic; `o_timeout` tied 0; a partial packet waits indefinitely.

## Structure
- Package `packet_assembler_pkg`: state enum `pa_state_t` {IDLE, RECEIVE, OUTPUT} and function `crc8_step(crc, data, poly)`.
- Sub-module `crc8_engine`:
  - Holds the CRC register; inputs: clear-to-init, byte-valid, data.
  - Output: current CRC.
  - Parameters `CRC_POLY`, `CRC_INIT`.

## Test plan
- Default params; bytes 00 00 00 00 00 00 then CRC 00 → `o_valid` next cycle, `o_message` = 48'h0, count 0.
- Bytes 00 00 00 00 00 01, CRC 07, `i_ready` low 5 cycles → `o_message` = 48'h010000000000 stable; clears the cycle after `i_ready`; `o_ready` 0 throughout.
- `MESSAGE_BYTES` = 9; ASCII "123456789" then F4 → valid. Same data with CRC F5 → `o_crc_error` pulse, count = 1, no `o_valid`.
- `ERR_CNT_WIDTH` = 2; five bad packets → count 1,2,3,3,3.
- Timeout macro on, `TIMEOUT_CYCLES` = 16:
  - 3 bytes then 16 idle cycles → one `o_timeout` pulse, then IDLE.
  - A following full good packet is received correctly.
  - A byte exactly at cycle 16 → no timeout.
- `reset` low during byte 4 and again during OUTPUT → all outputs 0 next cycle; the following packet is assembled from byte 0.
